// File: rtl/pmem_port_arbiter_if.sv
// pmem_port_arbiter_if
//   Bundles the fetch, LPM and program-memory signals of the program-flash
//   read-port arbiter.
//   slave  : arbiter side (drives fetch_valid/fetch_data, lpm_* results,
//            pc_stall and the pmem read request).
//   master : environment side (fetch unit, decode, register file and the
//            synchronous program memory).
//   ADDR_W : program-memory word-address width.
interface pmem_port_arbiter_if #(
    parameter int ADDR_W = 14
) ();
    // fetch path
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [15:0]       fetch_data;
    // LPM path
    logic              lpm_start;
    logic [15:0]       lpm_z;
    logic              lpm_postinc;
    logic              lpm_busy;
    logic              lpm_done;
    logic [7:0]        lpm_byte;
    logic              z_inc;
    logic              pc_stall;
    // program memory
    logic              pmem_en;
    logic [ADDR_W-1:0] pmem_addr;
    logic [15:0]       pmem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, lpm_start, lpm_z, lpm_postinc, pmem_rdata,
        output fetch_valid, fetch_data, lpm_busy, lpm_done, lpm_byte, z_inc,
               pc_stall, pmem_en, pmem_addr
    );

    modport master (
        output fetch_req, fetch_addr, lpm_start, lpm_z, lpm_postinc, pmem_rdata,
        input  fetch_valid, fetch_data, lpm_busy, lpm_done, lpm_byte, z_inc,
               pc_stall, pmem_en, pmem_addr
    );
endinterface

// File: rtl/pmem_port_arbiter.sv
// pmem_port_arbiter
//   Shares the single read port of the program flash between instruction
//   fetch and the LPM execution path. Fetch is stalled while the 3-cycle LPM
//   sequence (LPM_START, LPM_RD, LPM_CAP) runs; the addressed byte is
//   returned with lpm_done and, for LPM Rd,Z+, a z_inc pulse.
//   Ports:
//     clk      : system clock, rising edge
//     reset_n  : synchronous, active-low reset
//     bus      : pmem_port_arbiter_if.slave (fetch, LPM and pmem signals)
//   Build option:
//     LPM_POSTINC_EN : when defined, lpm_postinc is latched on lpm_start and
//                      drives z_inc in LPM_CAP; otherwise z_inc is tied low.
module pmem_port_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pmem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LPM_START = 2'd1,
        LPM_RD    = 2'd2,
        LPM_CAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] z_word_q, z_word_d;
    logic              z_lsb_q, z_lsb_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              lpm_busy_q, lpm_busy_d;
    logic              lpm_done_q, lpm_done_d;
    logic              z_inc_q, z_inc_d;
`ifdef LPM_POSTINC_EN
    logic              postinc_q, postinc_d;
`else
    logic              postinc_unused;
    assign postinc_unused = bus.lpm_postinc;
`endif

    logic              fetch_grant;
    logic              pmem_en_c;
    logic [ADDR_W-1:0] pmem_addr_c;
    logic              pc_stall_c;

    // Z bits above the flash size are dropped on purpose (address wraps).
    logic              lpm_z_unused;
    assign lpm_z_unused = ^bus.lpm_z;

    always_comb begin
        state_d     = state_q;
        z_word_d    = z_word_q;
        z_lsb_d     = z_lsb_q;
`ifdef LPM_POSTINC_EN
        postinc_d   = postinc_q;
`endif
        fetch_grant = 1'b0;
        pmem_en_c   = 1'b0;
        pmem_addr_c = bus.fetch_addr;
        pc_stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.lpm_start) begin
                    // LPM wins over a simultaneous fetch; fetch unit retries.
                    pc_stall_c = 1'b1;
                    z_word_d   = bus.lpm_z[ADDR_W:1];
                    z_lsb_d    = bus.lpm_z[0];
`ifdef LPM_POSTINC_EN
                    postinc_d  = bus.lpm_postinc;
`endif
                    state_d    = LPM_START;
                end else begin
                    fetch_grant = bus.fetch_req;
                    pmem_en_c   = bus.fetch_req;
                    pmem_addr_c = bus.fetch_addr;
                end
            end
            LPM_START: begin
                pc_stall_c = 1'b1;
                state_d    = LPM_RD;
            end
            LPM_RD: begin
                pc_stall_c  = 1'b1;
                pmem_en_c   = 1'b1;
                pmem_addr_c = z_word_q;
                state_d     = LPM_CAP;
            end
            LPM_CAP: begin
                pc_stall_c = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        fetch_valid_d = fetch_grant;
        lpm_busy_d    = (state_d != IDLE);
        lpm_done_d    = (state_d == LPM_CAP);
`ifdef LPM_POSTINC_EN
        z_inc_d       = (state_d == LPM_CAP) && postinc_q;
`else
        z_inc_d       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            z_word_q      <= '0;
            z_lsb_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            lpm_busy_q    <= 1'b0;
            lpm_done_q    <= 1'b0;
            z_inc_q       <= 1'b0;
`ifdef LPM_POSTINC_EN
            postinc_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            z_word_q      <= z_word_d;
            z_lsb_q       <= z_lsb_d;
            fetch_valid_q <= fetch_valid_d;
            lpm_busy_q    <= lpm_busy_d;
            lpm_done_q    <= lpm_done_d;
            z_inc_q       <= z_inc_d;
`ifdef LPM_POSTINC_EN
            postinc_q     <= postinc_d;
`endif
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = bus.pmem_rdata;
    assign bus.lpm_busy    = lpm_busy_q;
    assign bus.lpm_done    = lpm_done_q;
    assign bus.lpm_byte    = lpm_done_q ? (z_lsb_q ? bus.pmem_rdata[15:8]
                                                   : bus.pmem_rdata[7:0])
                                        : '0;
    assign bus.z_inc       = z_inc_q;
    assign bus.pc_stall    = pc_stall_c;
    assign bus.pmem_en     = pmem_en_c;
    assign bus.pmem_addr   = pmem_addr_c;

endmodule

// File: tb/tb_pmem_port_arbiter.sv
// tb_pmem_port_arbiter
//   Self-checking bench for pmem_port_arbiter: synchronous flash model,
//   directed stimulus, and a scoreboard of expected fetch words and LPM
//   results consumed by a negedge monitor.
module tb_pmem_port_arbiter;
    localparam int ADDR_W = 14;
`ifdef LPM_POSTINC_EN
    localparam bit POSTINC_EN = 1'b1;
`else
    localparam bit POSTINC_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    pmem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    pmem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    logic [15:0] flash [0:(1<<ADDR_W)-1];
    logic [15:0] fq [$];   // expected fetch words
    logic [8:0]  lq [$];   // expected {lpm_byte, z_inc}

    // synchronous program memory: data one cycle after pmem_en
    always @(posedge clk) begin
        if (bus.pmem_en === 1'b1)
            bus.pmem_rdata <= flash[bus.pmem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.fetch_valid === 1'b1) begin
                if (fq.size() == 0) chk("fetch_valid_unexpected", bus.fetch_valid, 0);
                else                chk("fetch_data", bus.fetch_data, fq.pop_front());
            end
            if (bus.lpm_done === 1'b1) begin
                if (lq.size() == 0) begin
                    chk("lpm_done_unexpected", bus.lpm_done, 0);
                end else begin
                    logic [8:0] e;
                    e = lq.pop_front();
                    chk("lpm_byte", bus.lpm_byte, e[8:1]);
                    chk("z_inc", bus.z_inc, e[0]);
                end
            end else begin
                chk("lpm_byte_idle", bus.lpm_byte, 0);
                chk("z_inc_idle", bus.z_inc, 0);
            end
        end
    end

    // One LPM sequence starting in IDLE; ends one cycle after re-grant.
    task automatic run_lpm(input logic [15:0] z, input bit pinc, input bit with_fetch,
                           input logic [ADDR_W-1:0] faddr, input bit restart_in_rd,
                           input logic [ADDR_W-1:0] exp_addr, input logic [7:0] exp_byte);
        bit exp_zinc;
        exp_zinc = pinc && POSTINC_EN;
        // cycle 0
        bus.lpm_start = 1'b1; bus.lpm_z = z; bus.lpm_postinc = pinc;
        bus.fetch_req = with_fetch; bus.fetch_addr = faddr;
        #1;
        chk("c0_pc_stall", bus.pc_stall, 1);
        chk("c0_pmem_en", bus.pmem_en, 0);
        chk("c0_lpm_busy", bus.lpm_busy, 0);
        lq.push_back({exp_byte, exp_zinc});
        tick;
        // cycle 1: LPM_START
        bus.lpm_start = 1'b0; bus.lpm_z = '0; bus.lpm_postinc = 1'b0;
        #1;
        chk("c1_fetch_valid", bus.fetch_valid, 0);
        chk("c1_pc_stall", bus.pc_stall, 1);
        chk("c1_lpm_busy", bus.lpm_busy, 1);
        chk("c1_pmem_en", bus.pmem_en, 0);
        chk("c1_lpm_done", bus.lpm_done, 0);
        tick;
        // cycle 2: LPM_RD
        bus.lpm_start = restart_in_rd;
        #1;
        chk("c2_pmem_en", bus.pmem_en, 1);
        chk("c2_pmem_addr", bus.pmem_addr, exp_addr);
        chk("c2_pc_stall", bus.pc_stall, 1);
        chk("c2_lpm_busy", bus.lpm_busy, 1);
        tick;
        // cycle 3: LPM_CAP
        bus.lpm_start = 1'b0;
        #1;
        chk("c3_lpm_done", bus.lpm_done, 1);
        chk("c3_pc_stall", bus.pc_stall, 1);
        chk("c3_lpm_busy", bus.lpm_busy, 1);
        chk("c3_pmem_en", bus.pmem_en, 0);
        tick;
        // cycle 4: IDLE, fetch re-granted
        #1;
        chk("c4_pc_stall", bus.pc_stall, 0);
        chk("c4_lpm_busy", bus.lpm_busy, 0);
        chk("c4_lpm_done", bus.lpm_done, 0);
        chk("c4_pmem_en", bus.pmem_en, with_fetch);
        if (with_fetch) begin
            chk("c4_pmem_addr", bus.pmem_addr, faddr);
            fq.push_back(flash[faddr]);
        end
        tick;
        // cycle 5
        bus.fetch_req = 1'b0;
        #1;
        chk("c5_fetch_valid", bus.fetch_valid, with_fetch);
        tick;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) flash[i] = 16'(i) ^ 16'hA5A5;
        flash[14'h0010] = 16'h940C;
        flash[14'h0080] = 16'hABCD;
        flash[14'h0020] = 16'h1234;
        flash[14'h3FFF] = 16'hBEEF;

        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.lpm_start = 1'b0;
        bus.lpm_z = '0; bus.lpm_postinc = 1'b0; bus.pmem_rdata = '0;

        // reset
        tick; tick;
        chk("rst_fetch_valid", bus.fetch_valid, 0);
        chk("rst_lpm_busy", bus.lpm_busy, 0);
        chk("rst_lpm_done", bus.lpm_done, 0);
        chk("rst_z_inc", bus.z_inc, 0);
        chk("rst_pc_stall", bus.pc_stall, 0);
        chk("rst_pmem_en", bus.pmem_en, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick;

        // back-to-back fetches at 0x0010
        chk("pre_fetch_valid", bus.fetch_valid, 0);
        for (int k = 0; k < 3; k++) begin
            bus.fetch_req = 1'b1; bus.fetch_addr = 14'h0010;
            #1;
            chk("fetch_pmem_en", bus.pmem_en, 1);
            chk("fetch_pmem_addr", bus.pmem_addr, 14'h0010);
            chk("fetch_pc_stall", bus.pc_stall, 0);
            fq.push_back(flash[14'h0010]);
            tick;
            bus.fetch_req = 1'b0;
            chk("fetch_valid_on", bus.fetch_valid, 1);
        end
        tick;
        chk("fetch_valid_off", bus.fetch_valid, 0);

        // LPM variants
        run_lpm(16'h0101, 1'b0, 1'b0, '0,        1'b0, 14'h0080, 8'hAB);
        run_lpm(16'h0100, 1'b1, 1'b0, '0,        1'b0, 14'h0080, 8'hCD);
        run_lpm(16'h0101, 1'b0, 1'b1, 14'h0020,  1'b0, 14'h0080, 8'hAB);
        run_lpm(16'hFFFF, 1'b1, 1'b0, '0,        1'b1, 14'h3FFF, 8'hBE);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("post_restart_busy", bus.lpm_busy, 0);
        end

        // reset during LPM_RD aborts the sequence
        bus.lpm_start = 1'b1; bus.lpm_z = 16'h0101; bus.lpm_postinc = 1'b1;
        tick;
        bus.lpm_start = 1'b0; bus.lpm_postinc = 1'b0;
        tick;
        #1;
        chk("abort_in_rd", bus.pmem_en, 1);
        reset_n = 1'b0;
        tick;
        chk("abort_lpm_busy", bus.lpm_busy, 0);
        chk("abort_pc_stall", bus.pc_stall, 0);
        chk("abort_lpm_done", bus.lpm_done, 0);
        chk("abort_z_inc", bus.z_inc, 0);
        chk("abort_fetch_valid", bus.fetch_valid, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("abort_no_done", bus.lpm_done, 0);
            chk("abort_no_zinc", bus.z_inc, 0);
        end

        chk("fetch_queue_drained", fq.size(), 0);
        chk("lpm_queue_drained", lq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pmem_port_arbiter.md
# pmem_port_arbiter

Sequencer and arbiter for the single read port of the program flash. It is shared between the instruction fetch path and the LPM execution path. It sits between the control units (which decode LPM, id 8'h22) and the synchronous program memory. It stalls fetch, runs the 3-cycle LPM sequence, selects the addressed byte and signals writeback and Z post-increment.

## Interface
- ADDR_W, 14, program-memory word-address width (16K words = 32 KB flash)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- fetch_req  in  1  fetch unit requests instruction word at fetch_addr
- fetch_addr  in  ADDR_W  PC (word address)
- fetch_valid  out  1  fetch_data holds the word for the fetch granted in the previous cycle
- fetch_data  out  16  pass-through of pmem_rdata
- lpm_start  in  1  one-cycle pulse from decode: execute LPM
- lpm_z  in  16  Z pointer (byte address), sampled on lpm_start
- lpm_postinc  in  1  LPM Rd,Z+ variant, sampled on lpm_start
- lpm_busy  out  1  LPM sequence in progress
- lpm_done  out  1  one-cycle pulse: lpm_byte valid, write to Rd
- lpm_byte  out  8  selected flash byte; 0 when lpm_done=0
- z_inc  out  1  one-cycle pulse, coincident with lpm_done: increment Z
- pc_stall  out  1  fetch/PC must hold
- pmem_en  out  1  memory read enable
- pmem_addr  out  ADDR_W  memory word address
- pmem_rdata  in  16  memory data, valid one cycle after pmem_en

## Operation
- FSM states: IDLE, LPM_START, LPM_RD, LPM_CAP.
- IDLE, lpm_start=0:
  - fetch_grant = fetch_req.
  - pmem_en = fetch_req; pmem_addr = fetch_addr.
- IDLE, lpm_start=1:
  - fetch not granted; pmem_en=0; pc_stall=1.
  - Latch z_word = lpm_z[ADDR_W:1], z_lsb = lpm_z[0] and postinc.
  - Next state LPM_START.
- LPM_START: pc_stall=1, lpm_busy=1, pmem_en=0; next LPM_RD.
- LPM_RD: pc_stall=1, lpm_busy=1, pmem_en=1, pmem_addr=z_word; next LPM_CAP.
- LPM_CAP:
  - pc_stall=1, lpm_busy=1, lpm_done=1.
  - lpm_byte = z_lsb ? pmem_rdata[15:8] : pmem_rdata[7:0].
  - z_inc = postinc.
  - Next state IDLE.
- fetch_valid register <= fetch_grant (fetch_req && state==IDLE && !lpm_start).
- pc_stall is combinational: (state!=IDLE) || (state==IDLE && lpm_start).
- lpm_start outside IDLE is ignored; no queuing.
- Z bits above ADDR_W+0 are ignored (address wraps modulo flash size).
- The Z increment itself, including 0xFFFF→0x0000 wrap, is done by the register file.
- Simultaneous fetch_req and lpm_start in IDLE: LPM wins and fetch is retried by the fetch unit after pc_stall drops.

## Timing
- Reset (reset_n=0 at a rising edge):
  - state=IDLE.
  - fetch_valid, lpm_busy, lpm_done, z_inc, pc_stall all 0; latched z_word, z_lsb, postinc all 0.
  - Combinational outputs follow IDLE rules once reset_n=1.
- LPM latency: lpm_start at cycle 0 → lpm_done and z_inc at cycle 3; first fetch re-granted at cycle 4 (matches the 3-cycle AVR LPM).
- pc_stall is high on cycles 0..3 inclusive.
- Fetch latency: 1 cycle (pmem_en at n → fetch_valid at n+1). Back-to-back fetches are allowed every cycle.
- Reset mid-LPM aborts the sequence: no lpm_done and no z_inc follow.

## Configuration
- LPM_POSTINC_EN defined: lpm_postinc is latched and drives z_inc in LPM_CAP.
- LPM_POSTINC_EN undefined: lpm_postinc is ignored, z_inc is tied to 0 and the postinc flop is removed. Plain LPM is unaffected.

## Test plan
- Reset then fetch_req=1, fetch_addr=0x0010 for 3 cycles, pmem returns 0x940C → fetch_valid=1 from cycle 1 with fetch_data=0x940C; pmem_addr=0x0010.
- lpm_start with lpm_z=0x0101, postinc=0, flash[0x0080]=0xABCD → pmem_addr=0x0080 in LPM_RD; lpm_byte=0xAB, lpm_done at cycle 3, z_inc=0; pc_stall high cycles 0–3.
- lpm_z=0x0100, postinc=1 → lpm_byte=0xCD, z_inc=1 with lpm_done (LPM_POSTINC_EN defined); z_inc=0 when the macro is undefined.
- fetch_req and lpm_start together in IDLE → no fetch_valid next cycle; LPM completes; fetch_valid resumes at cycle 5.
- lpm_z=0xFFFF, ADDR_W=14 → pmem_addr=0x3FFF, lpm_byte = high byte; second lpm_start during LPM_RD is ignored (single lpm_done).
- reset_n=0 during LPM_RD → next cycle state=IDLE, lpm_busy=0, and no lpm_done/z_inc in the following 4 cycles.
